// File: rtl/alu_serial_ctrl_pkg.sv
// Shared encodings for the bit-serial ALU controller and its 1-bit slice.
package alu_pkg;

    localparam logic [2:0] OP_ADD   = 3'b000;
    localparam logic [2:0] OP_SUB   = 3'b001;
    localparam logic [2:0] OP_AND   = 3'b010;
    localparam logic [2:0] OP_OR    = 3'b011;
    localparam logic [2:0] OP_XOR   = 3'b100;
    localparam logic [2:0] OP_NOT   = 3'b101;
    localparam logic [2:0] OP_PASSA = 3'b110;
    localparam logic [2:0] OP_PASSB = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Subtraction is a + ~b + 1: the slice inverts op2, the +1 enters as the initial carry.
    function automatic logic init_cin(input logic mode, input logic [2:0] opsel);
        return mode && (opsel == OP_SUB);
    endfunction

endpackage

// File: rtl/alu_serial_ctrl_if.sv
// Request/result bus plus the bit-level link to the 1-bit ALU slice.
interface alu_serial_ctrl_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [2:0]       opsel;
    logic             mode;

    logic             slice_op1;
    logic             slice_op2;
    logic             slice_cin;
    logic [2:0]       slice_opsel;
    logic             slice_mode;
    logic             slice_result;
    logic             slice_cout;

    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             c_flag;
    logic             z_flag;
    logic             o_flag;
    logic             s_flag;

    // slave = the controller; master = requester plus the slice it drives
    modport slave (
        input  start, a, b, opsel, mode, slice_result, slice_cout,
        output slice_op1, slice_op2, slice_cin, slice_opsel, slice_mode,
        output busy, done, result, c_flag, z_flag, o_flag, s_flag
    );

    modport master (
        output start, a, b, opsel, mode, slice_result, slice_cout,
        input  slice_op1, slice_op2, slice_cin, slice_opsel, slice_mode,
        input  busy, done, result, c_flag, z_flag, o_flag, s_flag
    );
endinterface

// File: rtl/alu_serial_ctrl.sv
// Bit-serial sequencer: feeds a 1-bit ALU slice LSB first, chains its carry,
// reassembles the result and produces C/Z/O/S flags with a one-cycle done pulse.
module alu_serial_ctrl
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    alu_serial_ctrl_if.slave  bus
);

    localparam int CW = $clog2(WIDTH);

    state_t           r_state;
    state_t           w_next;
    logic [WIDTH-1:0] r_a_sh;
    logic [WIDTH-1:0] r_b_sh;
    logic [WIDTH-1:0] r_res_sh;
    logic [WIDTH-1:0] r_result;
    logic [CW-1:0]    r_count;
    logic [2:0]       r_opsel;
    logic             r_mode;
    logic             r_carry;
    logic             r_zero_acc;
    logic             r_c;
    logic             r_z;
    logic             r_o;
    logic             r_s;
    logic             w_accept;
    logic             w_last;

    assign w_accept = (r_state == IDLE) && bus.start;
    assign w_last   = (r_state == RUN) && (r_count == CW'(WIDTH - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (bus.start) w_next = RUN;
            RUN:     if (w_last)    w_next = DONE;
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a_sh     <= '0;
            r_b_sh     <= '0;
            r_res_sh   <= '0;
            r_result   <= '0;
            r_count    <= '0;
            r_opsel    <= '0;
            r_mode     <= 1'b0;
            r_carry    <= 1'b0;
            r_zero_acc <= 1'b0;
            r_c        <= 1'b0;
            r_z        <= 1'b0;
            r_o        <= 1'b0;
            r_s        <= 1'b0;
        end else if (w_accept) begin
            r_a_sh     <= bus.a;
            r_b_sh     <= bus.b;
            r_res_sh   <= '0;
            r_opsel    <= bus.opsel;
            r_mode     <= bus.mode;
            r_carry    <= init_cin(bus.mode, bus.opsel);
            r_count    <= '0;
            r_zero_acc <= 1'b0;
        end else if (r_state == RUN) begin
            r_a_sh     <= r_a_sh >> 1;
            r_b_sh     <= r_b_sh >> 1;
            r_res_sh   <= {bus.slice_result, r_res_sh[WIDTH-1:1]};
            r_zero_acc <= r_zero_acc | bus.slice_result;
            r_carry    <= r_mode & bus.slice_cout;
            r_count    <= r_count + CW'(1);
            // Visible result/flags change only here so they stay stable between runs.
            if (w_last) begin
                r_result <= {bus.slice_result, r_res_sh[WIDTH-1:1]};
                r_c      <= r_mode & bus.slice_cout;
                r_o      <= r_mode & (r_carry ^ bus.slice_cout);
                r_s      <= bus.slice_result;
                r_z      <= ~(r_zero_acc | bus.slice_result);
            end
        end
    end

    assign bus.slice_op1   = r_a_sh[0];
    assign bus.slice_op2   = r_b_sh[0];
    assign bus.slice_cin   = r_carry;
    assign bus.slice_opsel = r_opsel;
    assign bus.slice_mode  = r_mode;
    assign bus.busy        = (r_state != IDLE);
    assign bus.done        = (r_state == DONE);
    assign bus.result      = r_result;
    assign bus.c_flag      = r_c;
    assign bus.z_flag      = r_z;
    assign bus.o_flag      = r_o;
    assign bus.s_flag      = r_s;

endmodule

// File: tb/tb_alu_serial_ctrl.sv
// Bench for alu_serial_ctrl with a behavioural 1-bit slice and a result scoreboard.
module tb_alu_serial_ctrl;
    import alu_pkg::*;

    localparam int WIDTH = 8;

    typedef struct {
        logic [2:0] opsel;
        logic       mode;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] res;
        logic       c;
        logic       z;
        logic       o;
        logic       s;
    } vec_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    int   n_vec = 0;
    int   n_err = 0;
    vec_t sb_q[$];
    vec_t tbl[11];

    always #5 clk = ~clk;

    alu_serial_ctrl_if #(.WIDTH(WIDTH)) bus();

    alu_serial_ctrl #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    // Behavioural slice: purely combinational from the controller's slice outputs.
    always_comb begin
        bus.slice_result = 1'b0;
        bus.slice_cout   = 1'b0;
        case (bus.slice_opsel)
            OP_ADD: begin
                bus.slice_result = bus.slice_op1 ^ bus.slice_op2 ^ bus.slice_cin;
                bus.slice_cout   = (bus.slice_op1 & bus.slice_op2) |
                                   (bus.slice_cin & (bus.slice_op1 ^ bus.slice_op2));
            end
            OP_SUB: begin
                bus.slice_result = bus.slice_op1 ^ ~bus.slice_op2 ^ bus.slice_cin;
                bus.slice_cout   = (bus.slice_op1 & ~bus.slice_op2) |
                                   (bus.slice_cin & (bus.slice_op1 ^ ~bus.slice_op2));
            end
            OP_AND:   bus.slice_result = bus.slice_op1 & bus.slice_op2;
            OP_OR:    bus.slice_result = bus.slice_op1 | bus.slice_op2;
            OP_XOR:   bus.slice_result = bus.slice_op1 ^ bus.slice_op2;
            OP_NOT:   bus.slice_result = ~bus.slice_op1;
            OP_PASSA: bus.slice_result = bus.slice_op1;
            default:  bus.slice_result = bus.slice_op2;
        endcase
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Word-level reference: integer add/sub for arithmetic, bitwise for logic mode.
    function automatic vec_t model(input logic [2:0] op, input logic m,
                                   input logic [7:0] a, input logic [7:0] b);
        vec_t       v;
        logic [8:0] s9;
        v.opsel = op; v.mode = m; v.a = a; v.b = b;
        v.c = 1'b0; v.o = 1'b0; v.res = '0;
        case (op)
            OP_ADD: if (m) begin
                s9 = {1'b0, a} + {1'b0, b};
                v.res = s9[7:0]; v.c = s9[8];
                v.o = (a[7] == b[7]) && (v.res[7] != a[7]);
            end else v.res = a ^ b;
            OP_SUB: if (m) begin
                s9 = {1'b0, a} + {1'b0, ~b} + 9'd1;
                v.res = s9[7:0]; v.c = s9[8];
                v.o = (a[7] != b[7]) && (v.res[7] != a[7]);
            end else v.res = a ^ ~b;
            OP_AND:   v.res = a & b;
            OP_OR:    v.res = a | b;
            OP_XOR:   v.res = a ^ b;
            OP_NOT:   v.res = ~a;
            OP_PASSA: v.res = a;
            default:  v.res = b;
        endcase
        v.z = (v.res == 8'h00);
        v.s = v.res[7];
        return v;
    endfunction

    function automatic logic [31:0] all_outs();
        return 32'({bus.busy, bus.done, bus.result, bus.c_flag, bus.z_flag, bus.o_flag,
                    bus.s_flag, bus.slice_op1, bus.slice_op2, bus.slice_cin,
                    bus.slice_opsel, bus.slice_mode});
    endfunction

    task automatic drive_start(input vec_t v);
        bus.a = v.a; bus.b = v.b; bus.opsel = v.opsel; bus.mode = v.mode;
        bus.start = 1'b1;
    endtask

    task automatic check_flags(input string tag, input vec_t e);
        check({tag, " result"}, 32'(bus.result), 32'(e.res));
        check({tag, " c"}, 32'(bus.c_flag), 32'(e.c));
        check({tag, " z"}, 32'(bus.z_flag), 32'(e.z));
        check({tag, " o"}, 32'(bus.o_flag), 32'(e.o));
        check({tag, " s"}, 32'(bus.s_flag), 32'(e.s));
    endtask

    // Entered and left at a negedge; the trailing IDLE cycle is where a back-to-back start lands.
    task automatic run_op(input vec_t v, input string tag);
        int   cyc;
        logic first_cin;
        logic any_cin;
        bit   seen;
        vec_t e;
        drive_start(v);
        sb_q.push_back(v);
        @(negedge clk);
        bus.start = 1'b0;
        cyc = 1; first_cin = bus.slice_cin; any_cin = 1'b0; seen = 0;
        while (!seen && cyc < 3 * WIDTH) begin
            any_cin |= bus.slice_cin;
            if (bus.done) seen = 1;
            else begin
                @(negedge clk);
                cyc++;
            end
        end
        if (!seen) begin
            n_vec++; n_err++;
            $display("FAIL %s timeout: no done within %0d cycles", tag, 3 * WIDTH);
            sb_q.delete();
        end else begin
            e = sb_q.pop_front();
            check({tag, " latency"}, 32'(cyc), 32'(WIDTH + 1));
            check_flags(tag, e);
            check({tag, " first cin"}, 32'(first_cin), 32'(v.mode && v.opsel == 3'b001));
            if (!v.mode) check({tag, " cin stays 0"}, 32'(any_cin), 32'(0));
            check({tag, " busy in done"}, 32'(bus.busy), 32'(1));
            @(negedge clk);
            check({tag, " done width"}, 32'(bus.done), 32'(0));
            check({tag, " busy after"}, 32'(bus.busy), 32'(0));
        end
    endtask

    initial begin
        int   dones;
        vec_t e;

        tbl[0]  = '{OP_ADD,   1'b1, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b0, 1'b1, 1'b1};
        tbl[1]  = '{OP_ADD,   1'b1, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[2]  = '{OP_SUB,   1'b1, 8'h05, 8'h05, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[3]  = '{OP_SUB,   1'b1, 8'h03, 8'h05, 8'hFE, 1'b0, 1'b0, 1'b0, 1'b1};
        tbl[4]  = '{OP_AND,   1'b0, 8'hF0, 8'h3C, 8'h30, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[5]  = '{OP_OR,    1'b0, 8'hF0, 8'h0C, 8'hFC, 1'b0, 1'b0, 1'b0, 1'b1};
        tbl[6]  = '{OP_XOR,   1'b0, 8'hAA, 8'hAA, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[7]  = '{OP_NOT,   1'b0, 8'h0F, 8'h00, 8'hF0, 1'b0, 1'b0, 1'b0, 1'b1};
        tbl[8]  = '{OP_PASSB, 1'b0, 8'h00, 8'h81, 8'h81, 1'b0, 1'b0, 1'b0, 1'b1};
        tbl[9]  = '{OP_SUB,   1'b1, 8'h80, 8'h01, 8'h7F, 1'b1, 1'b0, 1'b1, 1'b0};
        tbl[10] = '{OP_ADD,   1'b0, 8'hFF, 8'h01, 8'hFE, 1'b0, 1'b0, 1'b0, 1'b1};

        bus.start = 1'b0; bus.a = '0; bus.b = '0; bus.opsel = '0; bus.mode = 1'b0;
        #1 rst_n = 1'b0;
        #11 check("reset outputs", all_outs(), 32'(0));
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 11; i++) run_op(tbl[i], $sformatf("vec%0d", i));

        for (int i = 0; i < 12; i++)
            run_op(model(3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                         8'($urandom), 8'($urandom)), $sformatf("rnd%0d", i));

        // start pulse mid-run and in the DONE cycle must both be ignored
        drive_start(model(OP_ADD, 1'b1, 8'd12, 8'd34));
        sb_q.push_back(model(OP_ADD, 1'b1, 8'd12, 8'd34));
        @(negedge clk);
        bus.start = 1'b0;
        repeat (2) @(negedge clk);
        drive_start(model(OP_SUB, 1'b0, 8'hFF, 8'hFF));
        @(negedge clk);
        bus.start = 1'b0;
        dones = 0;
        for (int k = 0; k < 2 * WIDTH; k++) begin
            if (bus.done) begin
                dones++;
                if (dones == 1) begin
                    e = sb_q.pop_front();
                    check_flags("ignored start", e);
                    bus.start = 1'b1;
                    @(negedge clk);
                    bus.start = 1'b0;
                    check("start in done ignored", 32'(bus.busy), 32'(0));
                    continue;
                end
            end
            @(negedge clk);
        end
        check("single done pulse", 32'(dones), 32'(1));
        check("busy dropped", 32'(bus.busy), 32'(0));
        if (dones != 1) sb_q.delete();

        // async reset at count=4 aborts with no done pulse
        drive_start(model(OP_ADD, 1'b1, 8'h55, 8'h22));
        @(negedge clk);
        bus.start = 1'b0;
        repeat (4) @(negedge clk);
        check("busy before abort", 32'(bus.busy), 32'(1));
        rst_n = 1'b0;
        #1 check("abort outputs", all_outs(), 32'(0));
        dones = 0;
        repeat (2) begin
            @(negedge clk);
            dones += int'(bus.done);
        end
        rst_n = 1'b1;
        repeat (WIDTH + 2) begin
            @(negedge clk);
            dones += int'(bus.done);
        end
        check("no done after abort", 32'(dones), 32'(0));
        check("idle after abort", 32'(bus.busy), 32'(0));
        run_op(model(OP_ADD, 1'b1, 8'h10, 8'h20), "post reset");
        check("post reset value", 32'(bus.result), 32'h30);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
